// File: rtl/tim_dp_wires.sv
// Shared widths, index types and bank port records for the banked dual-port TIM.
// The bank vectors are sized by the configured bank count held here.
package tim_dp_wires;

  localparam int unsigned CFG_DEPTH = 256;
  localparam int unsigned CFG_WIDTH = 4;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BANK_W = $clog2(CFG_WIDTH);
  localparam int unsigned ROW_W  = $clog2(CFG_DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [BANK_W-1:0] bank_t;
  typedef logic [ROW_W-1:0]  row_t;

  typedef struct packed {
    logic  re;
    row_t  raddr;
    logic  we;
    row_t  waddr;
    word_t wdata;
  } bank_in_t;

  typedef struct packed {
    word_t rdata;
  } bank_out_t;

  typedef bank_in_t  [CFG_WIDTH-1:0] bank_in_vec_t;
  typedef bank_out_t [CFG_WIDTH-1:0] bank_out_vec_t;

  // Port-1 request as held for one cycle between grant and commit/response.
  typedef struct packed {
    logic  valid;
    logic  write;
    bank_t bank;
    row_t  row;
    word_t wdata;
    strb_t wstrb;
  } req_t;

  function automatic word_t merge_bytes(word_t old_word, word_t new_word, strb_t strb);
    word_t res;
    res = old_word;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tim_dp_if.sv
// Fetch (port 0) and data (port 1) request/response bundle of the TIM.
interface tim_dp_if;
  import tim_dp_wires::*;

  logic  p0_valid;
  addr_t p0_addr;
  logic  p0_gnt;
  word_t p0_rdata;
  logic  p0_ready;

  logic  p1_valid;
  addr_t p1_addr;
  word_t p1_wdata;
  strb_t p1_wstrb;
  logic  p1_gnt;
  word_t p1_rdata;
  logic  p1_ready;

  modport master (
    output p0_valid, p0_addr, p1_valid, p1_addr, p1_wdata, p1_wstrb,
    input  p0_gnt, p0_rdata, p0_ready, p1_gnt, p1_rdata, p1_ready
  );

  modport slave (
    input  p0_valid, p0_addr, p1_valid, p1_addr, p1_wdata, p1_wstrb,
    output p0_gnt, p0_rdata, p0_ready, p1_gnt, p1_rdata, p1_ready
  );
endinterface

// File: rtl/tim_dp_ram.sv
// One TIM bank: 32-bit words, one synchronous read port and one write port.
// A read and write of the same row in one cycle returns the old word.
module tim_dp_ram
  import tim_dp_wires::*;
#(
  parameter int unsigned DEPTH = CFG_DEPTH
) (
  input  logic      clock,
  input  bank_in_t  bank_in,
  output bank_out_t bank_out
);

  word_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (bank_in.we) mem[bank_in.waddr] <= bank_in.wdata;
    if (bank_in.re) bank_out.rdata <= mem[bank_in.raddr];
  end

endmodule

// File: rtl/tim_dp.sv
// Banked dual-port TIM: arbitration, read-modify-write merge, commit forwarding
// and response muxing around TIM_WIDTH single-bank RAMs.
module tim_dp
  import tim_dp_wires::*;
#(
  parameter int unsigned TIM_DEPTH = CFG_DEPTH,
  parameter int unsigned TIM_WIDTH = CFG_WIDTH
) (
  input logic     clock,
  input logic     reset,
  tim_dp_if.slave bus
);

  localparam int unsigned ROW_LO = BANK_W + 2;
  localparam int unsigned ROW_HI = ROW_LO + ROW_W - 1;

  bank_t b0, b1;
  row_t  r0, r1;
  logic  gnt0, gnt1, wr1;
  logic  unused_addr;

  assign b0  = bus.p0_addr[ROW_LO-1:2];
  assign b1  = bus.p1_addr[ROW_LO-1:2];
  assign r0  = bus.p0_addr[ROW_HI:ROW_LO];
  assign r1  = bus.p1_addr[ROW_HI:ROW_LO];
  assign wr1 = |bus.p1_wstrb;
  assign unused_addr = ^{bus.p0_addr[ADDR_W-1:ROW_HI+1], bus.p0_addr[1:0],
                         bus.p1_addr[ADDR_W-1:ROW_HI+1], bus.p1_addr[1:0]};

  // Port 1 always wins; port 0 stalls only on a same-bank collision.
  assign gnt1 = reset & bus.p1_valid;
  assign gnt0 = reset & bus.p0_valid & ~(bus.p1_valid & (b0 == b1));

  logic  s0_valid;
  bank_t s0_bank;
  req_t  s1;
  logic  fwd0, fwd1;
  word_t fwd_data;

  bank_in_vec_t  bank_in;
  bank_out_vec_t bank_out;

  word_t s0_word, s1_word, merged;
  logic  commit;

  // A word committed in the grant cycle overrides the stale RAM read.
  always_comb begin
    s0_word = fwd0 ? fwd_data : bank_out[s0_bank].rdata;
    s1_word = fwd1 ? fwd_data : bank_out[s1.bank].rdata;
    commit  = reset & s1.valid & s1.write;
    merged  = merge_bytes(s1_word, s1.wdata, s1.wstrb);
  end

  for (genvar i = 0; i < TIM_WIDTH; i++) begin : g_bank
    localparam bank_t IDX = BANK_W'(i);
    logic sel0, sel1;

    assign sel0 = gnt0 & (b0 == IDX);
    assign sel1 = gnt1 & (b1 == IDX);
    assign bank_in[i] = '{re:    sel0 | sel1,
                          raddr: sel1 ? r1 : r0,
                          we:    commit & (s1.bank == IDX),
                          waddr: s1.row,
                          wdata: merged};

    tim_dp_ram #(.DEPTH(TIM_DEPTH)) u_ram (
      .clock    (clock),
      .bank_in  (bank_in[i]),
      .bank_out (bank_out[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s0_valid <= 1'b0;
      s0_bank  <= '0;
      s1       <= '0;
      fwd0     <= 1'b0;
      fwd1     <= 1'b0;
      fwd_data <= '0;
    end else begin
      s0_valid <= gnt0;
      s0_bank  <= b0;
      s1       <= '{valid: gnt1, write: wr1, bank: b1, row: r1,
                    wdata: bus.p1_wdata, wstrb: bus.p1_wstrb};
      fwd0     <= commit & gnt0 & (b0 == s1.bank) & (r0 == s1.row);
      fwd1     <= commit & gnt1 & (b1 == s1.bank) & (r1 == s1.row);
      fwd_data <= merged;
    end
  end

  assign bus.p0_gnt   = gnt0;
  assign bus.p1_gnt   = gnt1;
  assign bus.p0_ready = s0_valid;
  assign bus.p1_ready = s1.valid;
  assign bus.p0_rdata = s0_valid ? s0_word : '0;
  assign bus.p1_rdata = (s1.valid && !s1.write) ? s1_word : '0;

endmodule

// File: tb/tb_tim_dp.sv
// Directed and randomized bench for tim_dp against a flat word-array model.
module tb_tim_dp;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tim_dp_if bus ();

  tim_dp #(.TIM_DEPTH(256), .TIM_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model memory indexed by word offset modulo 256*4 words.
  logic [31:0] mem [1024];

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] s);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[b*8 +: 8] = s[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check grants, then check the responses a cycle later.
  task automatic cycle(input logic v0, input logic [31:0] a0, input logic v1,
                       input logic [31:0] a1, input logic [31:0] wd, input logic [3:0] ws);
    logic g0, g1;
    logic [31:0] e0, e1;
    bus.p0_valid = v0; bus.p0_addr = a0;
    bus.p1_valid = v1; bus.p1_addr = a1; bus.p1_wdata = wd; bus.p1_wstrb = ws;
    #1;
    g1 = v1;
    g0 = v0 && !(v1 && (a0[3:2] == a1[3:2]));
    check("p0_gnt", 32'(bus.p0_gnt), 32'(g0));
    check("p1_gnt", 32'(bus.p1_gnt), 32'(g1));
    e0 = g0 ? mem[widx(a0)] : 32'h0;
    e1 = 32'h0;
    if (g1) begin
      if (ws == 4'h0) e1 = mem[widx(a1)];
      else mem[widx(a1)] = apply_strb(mem[widx(a1)], wd, ws);
    end
    @(posedge clock); #1;
    bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
    check("p0_ready", 32'(bus.p0_ready), 32'(g0));
    check("p0_rdata", bus.p0_rdata, e0);
    check("p1_ready", 32'(bus.p1_ready), 32'(g1));
    check("p1_rdata", bus.p1_rdata, e1);
  endtask

  initial begin
    logic [31:0] r, q, a0, a1, wd, saved;
    logic [3:0]  ws;

    bus.p0_valid = 1'b0; bus.p0_addr = '0;
    bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wstrb = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_p0_ready", 32'(bus.p0_ready), 32'h0);
    check("rst_p0_rdata", bus.p0_rdata, 32'h0);
    check("rst_p1_ready", 32'(bus.p1_ready), 32'h0);
    check("rst_p1_rdata", bus.p1_rdata, 32'h0);
    reset = 1'b1;

    // Give every word a known value
    for (int i = 0; i < 1024; i++) cycle(1'b0, '0, 1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full write then read-back
    cycle(1'b0, '0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h0, 4'h0);
    check("wr_rd_model", mem[widx(32'h100)], 32'hDEADBEEF);

    // Back-to-back partial writes accumulate
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h11223344, 4'hF);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h000000AA, 4'h1);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h0000BB00, 4'h2);
    cycle(1'b0, '0, 1'b1, 32'h100, 32'h0, 4'h0);
    check("partial_model", mem[widx(32'h100)], 32'h1122BBAA);

    // Different banks granted together
    cycle(1'b1, 32'h104, 1'b1, 32'h108, 32'h0, 4'h0);

    // Same-bank conflict: p0 stalls then retries
    cycle(1'b1, 32'h200, 1'b1, 32'h210, 32'h0BADF00D, 4'hF);
    cycle(1'b1, 32'h200, 1'b0, '0, 32'h0, 4'h0);

    // Write then immediate aliased read from the other port
    cycle(1'b0, '0, 1'b1, 32'h40, 32'h55, 4'hF);
    cycle(1'b1, 32'h1040, 1'b0, '0, 32'h0, 4'h0);
    check("alias_model", mem[widx(32'h1040)], 32'h00000055);

    // Reset asserted in the write-commit cycle discards the write
    saved = mem[widx(32'h300)];
    bus.p1_valid = 1'b1; bus.p1_addr = 32'h300; bus.p1_wdata = 32'hCAFEF00D; bus.p1_wstrb = 4'hF;
    #1;
    check("rstwr_gnt", 32'(bus.p1_gnt), 32'h1);
    @(posedge clock); #1;
    bus.p1_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    check("rstwr_p0_ready", 32'(bus.p0_ready), 32'h0);
    check("rstwr_p0_rdata", bus.p0_rdata, 32'h0);
    check("rstwr_p1_ready", 32'(bus.p1_ready), 32'h0);
    check("rstwr_p1_rdata", bus.p1_rdata, 32'h0);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b1, 32'h300, 32'h0, 4'h0);
    check("rstwr_model", mem[widx(32'h300)], saved);

    // Random traffic over a small aliased pool to hit conflicts and forwarding
    for (int n = 0; n < 600; n++) begin
      r  = $urandom;
      q  = $urandom;
      a0 = {r[31:12], 6'd0, r[7:6], r[3:2], r[1:0]};
      a1 = {q[31:12], 6'd0, q[7:6], q[3:2], q[1:0]};
      wd = $urandom;
      ws = (q[8]) ? 4'(q[11:9] + 3'd1) | 4'(q[12] << 3) : 4'h0;
      cycle(r[8] | r[9], a0, q[13] | q[14], a1, wd, ws);
    end

    cycle(1'b0, '0, 1'b0, '0, 32'h0, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
